// File: rtl/fan_off_timer_pkg.sv
// fan_off_timer_pkg: shared state/mode codes, defaults and the reload helper for the fan auto-off timer
package fan_off_timer_pkg;
  localparam logic IDLE  = 1'b0;
  localparam logic ARMED = 1'b1;
  localparam logic [1:0] TMR_OFF = 2'd0;
  localparam logic [1:0] TMR_5S  = 2'd1;
  localparam logic [1:0] TMR_10S = 2'd2;
  localparam logic [1:0] TMR_15S = 2'd3;
  localparam int DEF_CLKS_PER_SEC = 100_000_000;
  localparam int DEF_STEP_SEC     = 5;
  localparam int DEF_NUM_STEPS    = 3;
  // Seconds loaded for a given setting; kept in 8 bits because STEP_SEC*NUM_STEPS fits a byte.
  function automatic logic [7:0] reload_sec(input logic [1:0] mode, input logic [7:0] step);
    return 8'(mode) * step;
  endfunction
endpackage

// File: rtl/fan_off_timer_sec_prescaler.sv
// sec_prescaler: divides clk down to a one-cycle tick every CLKS_PER_SEC cycles while running
module sec_prescaler #(
  parameter int CLKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic run,
  input  logic clear,
  output logic tick
);
  localparam int CW = CLKS_PER_SEC > 1 ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SEC - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == LAST;
  // Count only while running; a tick, a clear or stopping all restart the second from zero.
  always_comb cnt_d = (!run || clear || tick) ? '0 : cnt_q + CW'(1);
  // Prescaler register.
  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/fan_off_timer.sv
// fan_off_timer: button-selected auto-off countdown that requests fan power-off on expiry
module fan_off_timer
  import fan_off_timer_pkg::*;
#(
  parameter int CLKS_PER_SEC = DEF_CLKS_PER_SEC,
  parameter int STEP_SEC     = DEF_STEP_SEC,
  parameter int NUM_STEPS    = DEF_NUM_STEPS
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       btn_timer_pedge,
  input  logic       fan_running,
  output logic [1:0] timer_mode,
  output logic [7:0] remaining_sec,
  output logic       timer_active,
  output logic       timeout_pulse
);
  localparam logic [1:0] MAX_MODE = 2'(NUM_STEPS);
  localparam logic [7:0] STEP     = 8'(STEP_SEC);
  logic       state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] rem_q, rem_d;
  logic       pulse_q, pulse_d;
  logic       tick, clear, run;
  logic       armed, cancel, press, wrap, step, tk, expire, to_off;
  sec_prescaler #(.CLKS_PER_SEC(CLKS_PER_SEC)) u_presc (
    .clk    (clk),
    .reset_p(reset_p),
    .run    (run),
    .clear  (clear),
    .tick   (tick)
  );
  // Resolve coincident events: losing fan power beats a press, a press beats a tick.
  always_comb begin
    armed  = state_q == ARMED;
    cancel = armed && !fan_running;
    press  = btn_timer_pedge && fan_running;
    wrap   = press && armed && mode_q == MAX_MODE;
    step   = press && !wrap;
    tk     = armed && fan_running && !btn_timer_pedge && tick;
    expire = tk && rem_q == 8'd1;
    to_off = cancel || wrap || expire;
  end
  // Next state: any path back to off lands in IDLE, a setting step lands in ARMED.
  always_comb state_d = to_off ? IDLE : step ? ARMED : state_q;
  // Next mode, seconds and pulse; a step reloads the full setting rather than adding to what is left.
  always_comb begin
    mode_d  = to_off ? TMR_OFF : step ? mode_q + 2'd1 : mode_q;
    rem_d   = to_off ? 8'd0 : step ? reload_sec(mode_q + 2'd1, STEP) : tk ? rem_q - 8'd1 : rem_q;
    pulse_d = expire;
    clear   = step;
    run     = state_d == ARMED;
  end
  // State and output registers.
  always_ff @(posedge clk or posedge reset_p)
    if (reset_p) begin
      state_q <= IDLE;
      mode_q  <= TMR_OFF;
      rem_q   <= 8'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
    end
  assign timer_mode    = mode_q;
  assign remaining_sec = rem_q;
  assign timer_active  = state_q;
  assign timeout_pulse = pulse_q;
endmodule

// File: tb/tb_fan_off_timer.sv
// tb_fan_off_timer: scoreboard bench comparing the timer against a time-stamp based reference model
module tb_fan_off_timer;
  localparam int CPS = 10;
  localparam int STEP = 5;
  localparam int NS = 3;
  logic clk = 1'b0;
  logic reset_p = 1'b1;
  logic btn = 1'b0;
  logic fan = 1'b0;
  logic [1:0] timer_mode;
  logic [7:0] remaining_sec;
  logic timer_active, timeout_pulse;
  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] rem;
    logic       act;
    logic       pulse;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_n = 0;
  int m_t0 = 0;
  int m_base = 0;
  int m_mode = 0;
  bit m_act = 1'b0;

  fan_off_timer #(.CLKS_PER_SEC(CPS), .STEP_SEC(STEP), .NUM_STEPS(NS)) dut (
    .clk            (clk),
    .reset_p        (reset_p),
    .btn_timer_pedge(btn),
    .fan_running    (fan),
    .timer_mode     (timer_mode),
    .remaining_sec  (remaining_sec),
    .timer_active   (timer_active),
    .timeout_pulse  (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mode"}, timer_mode, 0);
    chk({tag, "_rem"}, remaining_sec, 0);
    chk({tag, "_active"}, timer_active, 0);
    chk({tag, "_pulse"}, timeout_pulse, 0);
  endtask

  function automatic int m_rem();
    return m_act ? m_base - (m_n - m_t0) / CPS : 0;
  endfunction

  // Reference: seconds left = loaded seconds minus whole seconds elapsed since the last (re)load edge.
  task automatic model(input bit b, input bit f);
    bit p = 1'b0;
    exp_t e;
    m_n++;
    if (m_act) begin
      if (!f) begin
        m_act = 1'b0;
        m_mode = 0;
      end else if (b) begin
        if (m_mode == NS) begin
          m_act = 1'b0;
          m_mode = 0;
        end else begin
          m_mode++;
          m_base = m_mode * STEP;
          m_t0 = m_n;
        end
      end else if (m_n - m_t0 == m_base * CPS) begin
        m_act = 1'b0;
        m_mode = 0;
        p = 1'b1;
      end
    end else if (b && f) begin
      m_act = 1'b1;
      m_mode = 1;
      m_base = STEP;
      m_t0 = m_n;
    end
    e.mode = 2'(m_mode);
    e.rem = 8'(m_rem());
    e.act = m_act;
    e.pulse = p;
    q.push_back(e);
  endtask

  task automatic cycle(input bit b, input bit f);
    btn = b;
    fan = f;
    @(posedge clk);
    #1;
    model(b, f);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("timer_mode", timer_mode, e.mode);
      chk("remaining_sec", remaining_sec, e.rem);
      chk("timer_active", timer_active, e.act);
      chk("timeout_pulse", timeout_pulse, e.pulse);
    end
  end

  initial begin : stim
    bit rf;
    bit b;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_p = 1'b0;
    // basic countdown
    cycle(1, 1);
    repeat (55) cycle(0, 1);
    // mode cycling
    repeat (4) begin
      cycle(1, 1);
      cycle(0, 1);
      cycle(0, 1);
    end
    // press while fan off
    repeat (3) cycle(0, 0);
    cycle(1, 0);
    repeat (3) cycle(0, 0);
    // cancel mid countdown
    cycle(1, 1);
    cycle(1, 1);
    repeat (25) cycle(0, 1);
    cycle(0, 0);
    repeat (20) cycle(0, 0);
    // press coincident with a tick at 3 s left
    cycle(1, 1);
    while (m_n - m_t0 < 29) cycle(0, 1);
    cycle(1, 1);
    repeat (40) cycle(0, 1);
    cycle(1, 1);
    cycle(1, 1);
    // fan drop on the final tick
    cycle(1, 1);
    while (m_n - m_t0 < 49) cycle(0, 1);
    cycle(0, 0);
    repeat (3) cycle(0, 0);
    // async reset mid-prescale at 7 s
    cycle(1, 1);
    cycle(1, 1);
    while (m_n - m_t0 < 34) cycle(0, 1);
    @(negedge clk);
    #1;
    chk("pre_reset_rem", remaining_sec, 7);
    reset_p = 1'b1;
    #1;
    check_zero("async_reset");
    m_act = 1'b0;
    m_mode = 0;
    q.delete();
    @(posedge clk);
    #1;
    reset_p = 1'b0;
    cycle(1, 1);
    chk("rearm_rem", remaining_sec, 5);
    repeat (3) cycle(0, 1);
    // randomized traffic
    rf = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      b = $urandom_range(0, 79) == 0;
      if (rf) rf = $urandom_range(0, 149) != 0;
      else rf = $urandom_range(0, 9) == 0;
      cycle(b, rf);
    end
    repeat (2) @(posedge clk);
    #6;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fan_off_timer.md
Name: fan_off_timer

Overview:
Auto-off timer stage that sits directly upstream of the fan power controller. It consumes the one-cycle timer-button pulse and the fan-running status. It cycles the timer setting through off, 5 s, 10 s and 15 s, then counts down in whole seconds. On expiry it issues a one-cycle force-off pulse to the power controller. It also exports the remaining seconds and the setting for FND/LED display.

Parameters:
CLKS_PER_SEC, 100_000_000, clk cycles per 1 s tick (bench overrides to 10)
STEP_SEC, 5, seconds added per setting step
NUM_STEPS, 3, number of non-off settings; STEP_SEC*NUM_STEPS must be <= 255

Ports:
clk  input  1  system clock
reset_p  input  1  asynchronous active-high reset
btn_timer_pedge  input  1  one-cycle pulse per timer-button press
fan_running  input  1  high while power duty != 0
timer_mode  output  2  0=off, 1..NUM_STEPS = selected setting
remaining_sec  output  8  seconds left, unsigned binary
timer_active  output  1  high while countdown is running
timeout_pulse  output  1  one-cycle force-off request to power controller

Behaviour:
- One clock domain. Reset is asynchronous and active-high. All outputs are registered.
- Reset values: timer_mode=0, remaining_sec=0, timer_active=0, timeout_pulse=0, state=IDLE, prescaler=0.
- States:
  - IDLE: timer_active=0.
  - ARMED: timer_active=1, prescaler running.
  - Timeout is not a separate state; timeout_pulse is a registered one-shot.
- Prescaler:
  - Counts 0..CLKS_PER_SEC-1 only in ARMED; held at 0 otherwise.
  - tick = prescaler at terminal count; the prescaler wraps to 0 on tick.
- IDLE + btn_timer_pedge + fan_running:
  - Go to ARMED, timer_mode=1, remaining_sec=STEP_SEC, prescaler cleared.
  - Visible the cycle after the pulse edge.
- IDLE + btn_timer_pedge + !fan_running: ignored, no state change.
- ARMED + btn_timer_pedge:
  - If timer_mode < NUM_STEPS: timer_mode+1, remaining_sec = (timer_mode+1)*STEP_SEC. This is a fresh reload, not an add to the time left. Prescaler cleared.
  - If timer_mode == NUM_STEPS: back to IDLE, timer_mode=0, remaining_sec=0, no timeout_pulse.
- ARMED + tick:
  - remaining_sec > 1: decrement by 1.
  - remaining_sec == 1: next cycle remaining_sec=0, timer_mode=0, state=IDLE, timeout_pulse=1 for exactly one cycle.
- ARMED + !fan_running:
  - Cancel to IDLE with timer_mode=0, remaining_sec=0, no timeout_pulse.
  - Cancel has the highest priority.
- Priority when events coincide in one cycle: cancel (!fan_running) > button > tick.
  - A button pulse coincident with a tick reloads the count, and the tick is discarded.
  - A cancel coincident with the final tick suppresses timeout_pulse.
- Timeout latency: timeout_pulse is high in the cycle after the clk edge on which the final tick occurs.
- remaining_sec never underflows; it reaches 0 only via expiry, cancel, or wrap to off.
- Reset mid-countdown returns everything to reset values immediately, with no pulse.
- Width rule: the reload product (timer_mode*STEP_SEC) is computed in 8 bits; the parameter constraint guarantees no overflow.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=1'b0, ARMED=1'b1.
  - Mode codes: TMR_OFF=2'd0, TMR_5S=2'd1, TMR_10S=2'd2, TMR_15S=2'd3.
  - Default STEP_SEC and CLKS_PER_SEC.
- Sub-module: sec_prescaler.
  - Inputs clk, reset_p, run, clear. Output tick.
  - Parameterised by CLKS_PER_SEC.
  - Reusable by other timed features.
- FSM, mode register and down-counter stay in fan_off_timer.

Test Plan:
1. Basic countdown (CLKS_PER_SEC=10): fan_running=1, one button pulse -> timer_mode=1, remaining_sec=5. Then 5,4,3,2,1 each 10 cycles; timeout_pulse high 1 cycle exactly 50 cycles after arming; then remaining_sec=0, timer_mode=0, timer_active=0.
2. Mode cycling: four pulses 3 cycles apart -> remaining_sec 5, 10, 15, then 0 with timer_mode 1, 2, 3, 0; no timeout_pulse at any point.
3. Press while fan off: fan_running=0, pulse -> all outputs stay 0.
4. Cancel: arm to 10 s, drop fan_running after 25 cycles -> next cycle IDLE, remaining_sec=0, no timeout_pulse ever.
5. Coincidence: pulse coincident with a tick at remaining_sec=3, mode 1 -> remaining_sec=10 (not 9), prescaler restarts. Separately, fan drop on the final tick -> no pulse.
6. Async reset at remaining_sec=7 mid-prescale -> outputs zero immediately without a clk edge; the next pulse after release arms at 5.
